branch_recovery_ctrl: RTL
=========================

Name: branch_recovery_ctrl

Overview:
Consumes the flush request and the picked mispredicted-lane index from the 4-wide branch resolution stage and performs misprediction recovery. It squashes lanes younger than the mispredicted branch, fires a checkpoint restore for the rename map, and holds the front end stalled for a fixed restore window. It then hands the corrected PC to fetch over a valid/ready handshake. It sits between branch resolution and the fetch/rename stages.

Parameters:
PC_W, 32, width of a program counter.
CKPT_CYCLES, 3, number of cycles spent in RESTORE. Legal range is 1..15.
CNT_W, 16, width of the saturating recovery counter.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
flush_in  input  1  a misprediction has been resolved this cycle
pick_branch_in  input  2  index (0..3) of the oldest mispredicted lane
lane_valid_in  input  4  bit i set means lane i holds a live instruction
target_pc_in  input  4*PC_W  corrected PC per lane; lane i occupies bits [i*PC_W +: PC_W]
redirect_ready  input  1  fetch accepts the redirect
squash_mask  output  4  one-cycle pulse; lanes to kill
ckpt_restore  output  1  one-cycle pulse; restore the rename checkpoint
ckpt_id  output  2  checkpoint/lane index to restore; valid while ckpt_restore is high
stall_out  output  1  freeze the front end
redirect_valid  output  1  redirect_pc is valid
redirect_pc  output  PC_W  corrected fetch PC
flush_overrun  output  1  sticky; a flush arrived while busy
recovery_count  output  CNT_W  number of accepted recoveries, saturating

Behaviour:
- Reset, asynchronous on rst_n low, forces:
  - state = IDLE
  - all outputs = 0, including redirect_pc, recovery_count and flush_overrun
  - internal captured PC, index and restore counter = 0
- Reset mid-recovery aborts immediately: no redirect is issued after reset releases.
- FSM states: IDLE, RESTORE, REDIRECT. All outputs are registered.
- IDLE:
  - flush_in is sampled only in IDLE. When flush_in=1 at edge N:
    - Capture pc_q = target_pc_in lane pick_branch_in.
    - Capture id_q = pick_branch_in.
  - In cycle N+1:
    - squash_mask[i] = lane_valid_in[i] && (i > pick_branch_in), using values sampled at N. The mispredicted lane itself is never squashed.
    - ckpt_restore = 1 and ckpt_id = id_q, for exactly one cycle.
    - stall_out = 1 and state = RESTORE, with the restore counter loaded to CKPT_CYCLES-1.
    - recovery_count increments, saturating at all-ones.
- RESTORE:
  - stall_out = 1.
  - The counter decrements each cycle. At 0, the next state is REDIRECT.
  - RESTORE therefore occupies exactly CKPT_CYCLES cycles (N+1 .. N+CKPT_CYCLES).
- REDIRECT:
  - redirect_valid = 1, redirect_pc = pc_q, stall_out = 1.
  - redirect_pc stays stable until the handshake completes.
  - On an edge with redirect_valid && redirect_ready: the next state is IDLE, with redirect_valid=0 and stall_out=0.
  - If redirect_ready is held high, the first redirect cycle is N+CKPT_CYCLES+1, and IDLE with stall_out=0 is reached at N+CKPT_CYCLES+2.
- redirect_ready outside REDIRECT is ignored.
- In IDLE, squash_mask, ckpt_restore and redirect_valid are 0.
- flush_in=1 in any non-IDLE state, including the handshake-completion cycle:
  - The flush is dropped: no capture, no pulse, no count.
  - flush_overrun is set and stays set until reset.
- Back-to-back flushes: a flush in the first IDLE cycle after a completed handshake is accepted normally.
- pick_branch_in=3 yields squash_mask=0 for that recovery.
- pick_branch_in and target_pc_in are don't-care when flush_in=0.

Test Plan:
1. Basic recovery:
   - Stimulus: reset, then flush_in=1, pick=1, lane_valid=4'b1111, target lane1=32'h0000_4000, redirect_ready=1, CKPT_CYCLES=3.
   - Required: squash_mask=4'b1100 and ckpt_restore=1 with ckpt_id=1 at N+1; stall_out high N+1..N+4; redirect_valid with redirect_pc=32'h4000 at N+4; stall_out=0 at N+5; recovery_count=1.
2. Backpressure:
   - Stimulus: same as 1, with redirect_ready=0 for 5 REDIRECT cycles, then 1.
   - Required: redirect_valid and redirect_pc=32'h4000 held stable for 6 cycles; IDLE on the cycle after ready.
3. Lane edges:
   - Stimulus: pick=0 with lane_valid=4'b0101.
   - Required: squash_mask=4'b0100.
   - Stimulus: pick=3.
   - Required: squash_mask=4'b0000, ckpt_id=3, redirect_pc = lane3 target.
4. Overrun:
   - Stimulus: flush in IDLE, then a second flush (pick=2, different PC) during RESTORE and another in the handshake-completion cycle.
   - Required: only the first PC is redirected; recovery_count=1; flush_overrun=1 and it stays set.
5. Reset mid-operation:
   - Stimulus: assert rst_n=0 during REDIRECT.
   - Required: all outputs are 0 immediately (asynchronously); after release, no redirect_valid appears, and a new flush recovers normally.
6. Saturation / back-to-back:
   - Stimulus: CNT_W=4, 17 recoveries with a flush on the first IDLE cycle after each handshake.
   - Required: every flush is accepted; recovery_count stops at 4'hF.

Source files
------------

// File: rtl/branch_recovery_ctrl_if.sv
// Recovery bus between branch resolution, the recovery controller and fetch/rename.
// The slave modport is the controller side; the master modport is the environment side.
interface branch_recovery_ctrl_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
);
   logic              flush_in;
   logic [1:0]        pick_branch_in;
   logic [3:0]        lane_valid_in;
   logic [4*PC_W-1:0] target_pc_in;
   logic              redirect_ready;
   logic [3:0]        squash_mask;
   logic              ckpt_restore;
   logic [1:0]        ckpt_id;
   logic              stall_out;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              flush_overrun;
   logic [CNT_W-1:0]  recovery_count;

   modport slave (
      input  flush_in, pick_branch_in, lane_valid_in, target_pc_in, redirect_ready,
      output squash_mask, ckpt_restore, ckpt_id, stall_out, redirect_valid,
             redirect_pc, flush_overrun, recovery_count
   );

   modport master (
      output flush_in, pick_branch_in, lane_valid_in, target_pc_in, redirect_ready,
      input  squash_mask, ckpt_restore, ckpt_id, stall_out, redirect_valid,
             redirect_pc, flush_overrun, recovery_count
   );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// Misprediction recovery: squash younger lanes, pulse a checkpoint restore, stall for a
// fixed restore window, then hand the corrected PC to fetch over valid/ready.
module branch_recovery_ctrl #(
   parameter int PC_W        = 32,
   parameter int CKPT_CYCLES = 3,
   parameter int CNT_W       = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   branch_recovery_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RESTORE  = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [1:0]        id_q, id_d;
   logic [3:0]        squash_q, squash_d;
   logic              restore_q, restore_d;
   logic [1:0]        ckpt_id_q, ckpt_id_d;
   logic              stall_q, stall_d;
   logic              valid_q, valid_d;
   logic [PC_W-1:0]   rpc_q, rpc_d;
   logic              overrun_q, overrun_d;
   logic [CNT_W-1:0]  count_q, count_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_d      = pc_q;
      id_d      = id_q;
      squash_d  = '0;
      restore_d = 1'b0;
      ckpt_id_d = ckpt_id_q;
      stall_d   = stall_q;
      valid_d   = 1'b0;
      rpc_d     = rpc_q;
      overrun_d = overrun_q;
      count_d   = count_q;

      case (state_q)
         IDLE: begin
            stall_d = 1'b0;
            if (bus.flush_in) begin
               pc_d      = bus.target_pc_in[int'(bus.pick_branch_in)*PC_W +: PC_W];
               id_d      = bus.pick_branch_in;
               ckpt_id_d = bus.pick_branch_in;
               for (int i = 0; i < 4; i++)
                  squash_d[i] = bus.lane_valid_in[i] && (i > int'(bus.pick_branch_in));
               restore_d = 1'b1;
               stall_d   = 1'b1;
               cnt_d     = 4'(CKPT_CYCLES - 1);
               count_d   = sat_inc(count_q);
               state_d   = RESTORE;
            end
         end
         RESTORE: begin
            stall_d = 1'b1;
            if (bus.flush_in) overrun_d = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = REDIRECT;
               valid_d = 1'b1;
               rpc_d   = pc_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         REDIRECT: begin
            if (bus.flush_in) overrun_d = 1'b1;
            // valid is high for the whole of REDIRECT, so ready alone completes the handshake
            if (bus.redirect_ready) begin
               state_d = IDLE;
               stall_d = 1'b0;
               valid_d = 1'b0;
            end else begin
               stall_d = 1'b1;
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            stall_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pc_q      <= '0;
         id_q      <= '0;
         squash_q  <= '0;
         restore_q <= 1'b0;
         ckpt_id_q <= '0;
         stall_q   <= 1'b0;
         valid_q   <= 1'b0;
         rpc_q     <= '0;
         overrun_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pc_q      <= pc_d;
         id_q      <= id_d;
         squash_q  <= squash_d;
         restore_q <= restore_d;
         ckpt_id_q <= ckpt_id_d;
         stall_q   <= stall_d;
         valid_q   <= valid_d;
         rpc_q     <= rpc_d;
         overrun_q <= overrun_d;
         count_q   <= count_d;
      end
   end

   assign bus.squash_mask    = squash_q;
   assign bus.ckpt_restore   = restore_q;
   assign bus.ckpt_id        = ckpt_id_q;
   assign bus.stall_out      = stall_q;
   assign bus.redirect_valid = valid_q;
   assign bus.redirect_pc    = rpc_q;
   assign bus.flush_overrun  = overrun_q;
   assign bus.recovery_count = count_q;

endmodule
